serial_adder: RTL
=================

// Module: serial_adder
// PURPOSE
//  Bit-serial WIDTH-bit adder built around one FullAdder instance and a registered carry.
//  Accepts an operand pair over a valid/ready handshake and adds one bit per clock, LSB first.
//  Presents the sum and carry-out over a valid/ready handshake.
//  Sits directly upstream of the FullAdder: feeds it operand bits and carry, and consumes s/c_out.
// PARAMETERS
//  WIDTH  8  operand/sum width in bits; legal range >= 2
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand pair a/b/c_in is valid
//  in_ready   out  1      block can accept an operand pair (high only in IDLE)
//  a          in   WIDTH  operand A, sampled on the accept edge
//  b          in   WIDTH  operand B, sampled on the accept edge
//  c_in       in   1      carry-in, sampled on the accept edge
//  out_valid  out  1      sum/c_out valid (high only in DONE)
//  out_ready  in   1      consumer takes the result
//  sum        out  WIDTH  a + b + c_in, modulo 2^WIDTH
//  c_out      out  1      carry out of bit WIDTH-1
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  - Reset: state=IDLE; sum=0, c_out=0, out_valid=0, busy=0; in_ready=1 from the first cycle after reset.
//  - rst has priority over every other event. Reset mid-RUN or mid-DONE discards the operation.
//  - FSM states: IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: in_ready=1. On in_valid&&in_ready:
//    - load shift registers: a_sr=a, b_sr=b.
//    - carry reg = c_in; bit counter cnt = 0; state -> RUN.
//  - RUN: FullAdder inputs are a_sr[0], b_sr[0] and the carry reg. Each edge:
//    - a_sr and b_sr shift right by 1.
//    - sum_sr = {s, sum_sr[WIDTH-1:1]}.
//    - carry reg = FullAdder c_out; cnt = cnt + 1.
//  - RUN exit: at cnt == WIDTH-1, the same edge moves state -> DONE. RUN lasts exactly WIDTH cycles.
//  - Latency: out_valid rises WIDTH clock edges after the accepting edge.
//  - cnt is $clog2(WIDTH) bits wide and never wraps past WIDTH-1.
//  - DONE: out_valid=1; sum=sum_sr; c_out=carry reg. Outputs are held stable while out_ready=0.
//    On out_valid&&out_ready: state -> IDLE, out_valid drops on that edge.
//  - No overlap: in_valid is ignored in RUN and DONE, so a new pair is accepted no earlier than
//    the cycle after the result is taken.
//  - Input changes on a/b/c_in after the accept edge have no effect on the running operation.
//  - sum/c_out retain their last values in IDLE; only out_valid qualifies them.
// CONFIGURATION
//  SERIAL_ADDER_OVF_EN
//  - Defined: adds output port ovf (1 bit). ovf = signed two's-complement overflow
//    = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
//    - The carry into bit WIDTH-1 is captured in a register on the edge where cnt == WIDTH-2.
//    - ovf is valid with out_valid; reset value 0.
//  - Undefined: no ovf port, no extra register; behaviour otherwise identical.
// TESTING
//  (WIDTH=8)
//  1. a=0x0F, b=0x01, c_in=0 accepted -> out_valid exactly 8 cycles later.
//     sum=0x10, c_out=0, ovf=0.
//  2. a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1, ovf=0.
//     a=0x7F, b=0x01, c_in=0 -> sum=0x80, c_out=0, ovf=1.
//  3. a=0xFF, b=0x00, c_in=1 -> sum=0x00, c_out=1.
//     a=0x80, b=0x80, c_in=0 -> sum=0x00, c_out=1, ovf=1.
//  4. Hold out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands driven:
//     - out_valid, sum and c_out stay stable; in_ready=0.
//     - out_ready=1 -> IDLE next cycle; the new pair is accepted in the cycle after that.
//  5. Assert rst for 1 cycle after 3 RUN cycles -> next cycle: state IDLE, out_valid=0,
//     in_ready=1, busy=0, sum=0; the next operation (0x12+0x34) gives sum=0x46.
//  6. Random 1000 pairs with random in_valid/out_ready stalls:
//     - every result equals {c_out,sum} = a+b+c_in.
//     - no result is lost or duplicated.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built around one full_adder cell, LSB first.
// Optional feature macro SERIAL_ADDER_OVF_EN adds a registered signed-overflow output (ovf).

module full_adder (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic s,
   output logic c_out
);
   assign s     = a ^ b ^ c_in;
   assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-2:0] sum_sr;
   logic [WIDTH-1:0] sum_nx;
   logic             carry;
   logic             fa_s;
   logic             fa_c;
   logic [CW-1:0]    cnt;
   logic             last_bit;

   full_adder u_fa (
      .a     (a_sr[0]),
      .b     (b_sr[0]),
      .c_in  (carry),
      .s     (fa_s),
      .c_out (fa_c)
   );

   // The newest sum bit enters at the MSB; the full word is complete on the last RUN edge.
   assign sum_nx   = {fa_s, sum_sr};
   assign last_bit = (state == RUN) && (cnt == LAST);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (in_valid) state_nx = RUN;
            else          state_nx = IDLE;
         end
         RUN: begin
            if (cnt == LAST) state_nx = DONE;
            else             state_nx = RUN;
         end
         DONE: begin
            if (out_ready) state_nx = IDLE;
            else           state_nx = DONE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
      end else if ((state == IDLE) && in_valid) begin
         a_sr  <= a;
         b_sr  <= b;
         carry <= c_in;
         cnt   <= '0;
      end else if (state == RUN) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         sum_sr <= sum_nx[WIDTH-1:1];
         carry  <= fa_c;
         // cnt saturates at LAST so it never wraps for power-of-two widths.
         if (cnt != LAST) cnt <= cnt + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         sum       <= '0;
         c_out     <= 1'b0;
      end else begin
         in_ready  <= (state_nx == IDLE);
         out_valid <= (state_nx == DONE);
         busy      <= (state_nx != IDLE);
         if (last_bit) begin
            sum   <= sum_nx;
            c_out <= fa_c;
         end
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);
   logic c_msb;

   // Carry into the MSB is the full-adder carry produced while adding bit WIDTH-2.
   always_ff @(posedge clk) begin
      if (rst) begin
         c_msb <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         if ((state == RUN) && (cnt == PENULT)) c_msb <= fa_c;
         if (last_bit) ovf <= c_msb ^ fa_c;
      end
   end
`endif

endmodule
